// File: rtl/word_tx_serializer_pkg.sv
// Shared debug-link definitions: word geometry, guard gap default and serializer state encoding.
package word_tx_serializer_pkg;

    localparam int unsigned LINK_NBITS      = 32;
    localparam int unsigned LINK_DBIT       = 8;
    localparam int unsigned LINK_GAP_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic int unsigned nbytes(input int unsigned nbits, input int unsigned dbit);
        return nbits / dbit;
    endfunction

    localparam int unsigned LINK_NBYTES = nbytes(LINK_NBITS, LINK_DBIT);

endpackage

// File: rtl/word_tx_serializer_if.sv
// Debug-link transmit bundle: controller word port on one side, UART byte port on the other.
interface word_tx_serializer_if #(
    parameter int unsigned NBITS = word_tx_serializer_pkg::LINK_NBITS,
    parameter int unsigned DBIT  = word_tx_serializer_pkg::LINK_DBIT
);
    logic [NBITS-1:0] tx_Data;
    logic             tx_start;
    logic             tx_done;
    logic             busy;
    logic             uart_tx_done;
    logic [DBIT-1:0]  uart_tx_data;
    logic             uart_tx_start;

    modport slave (
        input  tx_Data, tx_start, uart_tx_done,
        output tx_done, busy, uart_tx_data, uart_tx_start
    );

    modport master (
        output tx_Data, tx_start, uart_tx_done,
        input  tx_done, busy, uart_tx_data, uart_tx_start
    );
endinterface

// File: rtl/word_tx_serializer.sv
// Splits each accepted word into LSB-first bytes for the UART, then holds off a guard gap
// so the controller can present its next word before tx_start is sampled again.
module word_tx_serializer
    import word_tx_serializer_pkg::*;
#(
    parameter int unsigned NBITS      = LINK_NBITS,
    parameter int unsigned DBIT       = LINK_DBIT,
    parameter int unsigned GAP_CYCLES = LINK_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    word_tx_serializer_if.slave   bus
);

    localparam int unsigned NBYTES = nbytes(NBITS, DBIT);
    localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned GW     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t           r_state;
    logic [NBITS-1:0] r_shift;
    logic [BW-1:0]    r_byte;
    logic [GW-1:0]    r_gap;
    logic             r_start;
    logic             r_done;
    logic             r_busy;

    assign bus.uart_tx_data  = r_shift[DBIT-1:0];
    assign bus.uart_tx_start = r_start;
    assign bus.tx_done       = r_done;
    assign bus.busy          = r_busy;

    // Strobes default low each cycle and are raised only on the edge entering SEND / GAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_byte  <= '0;
            r_gap   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        r_shift <= bus.tx_Data;
                        r_byte  <= '0;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.uart_tx_done) begin
                        if (r_byte == BW'(NBYTES - 1)) begin
                            r_gap   <= '0;
                            r_done  <= 1'b1;
                            r_state <= ST_GAP;
                        end else begin
                            r_shift <= r_shift >> DBIT;
                            r_byte  <= r_byte + BW'(1);
                            r_start <= 1'b1;
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_GAP: begin
                    // Exit lands exactly GAP_CYCLES cycles after tx_done rose.
                    r_gap <= r_gap + GW'(1);
                    if (r_gap == GW'(GAP_CYCLES - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/word_tx_serializer.md
# word_tx_serializer

Transmit-side word serializer for the debug link. It sits between the debug controller's 32-bit transmit port (`tx_Data`/`tx_start`/`tx_done`) and the byte-wide UART transmitter. Each accepted word is split into bytes and sent least-significant byte first, with a one-cycle start pulse handed to the UART for every byte. One `tx_done` pulse is returned per completed word. A programmable guard gap then gives the controller time to present its next word before `tx_start` is sampled again.

## Interface
- `NBITS`, 32: word width; must be a multiple of `DBIT`.
- `DBIT`, 8: UART byte width.
- `GAP_CYCLES`, 3: guard cycles after each word before `tx_start` is sampled again; minimum 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_Data`  in  NBITS  word to send; sampled only at acceptance.
- `tx_start`  in  1  level request; may be held high continuously.
- `uart_tx_done`  in  1  one-cycle tick from the UART transmitter: the current byte has been fully sent.
- `uart_tx_data`  out  DBIT  byte presented to the UART.
- `uart_tx_start`  out  1  one-cycle pulse that starts one UART byte.
- `tx_done`  out  1  one-cycle pulse: the whole word has been sent.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Derived constant: `NBYTES = NBITS/DBIT`, which is 4 at the defaults.
- Internal registers:
  - shift register, NBITS wide;
  - byte counter, clog2(NBYTES) wide;
  - gap counter, clog2(GAP_CYCLES+1) wide.
- States and transitions:
  - IDLE: if `tx_start`=1, load the shift register with `tx_Data`, clear the byte counter, go to SEND. Otherwise stay.
  - SEND: single cycle. `uart_tx_start`=1. Always go to WAIT.
  - WAIT: hold until `uart_tx_done`=1.
    - If byte counter = NBYTES-1: clear the gap counter and go to GAP.
    - Otherwise: shift the register right by DBIT, increment the byte counter, go to SEND.
  - GAP: increment the gap counter each cycle. When the gap counter reaches GAP_CYCLES-1, go to IDLE. `tx_done`=1 only in the first GAP cycle (gap counter = 0).
- `uart_tx_data` always equals shift register bits [DBIT-1:0]. It is therefore stable from SEND through the end of WAIT for each byte.
- Byte order on the line: `tx_Data`[7:0], then [15:8], [23:16], [31:24].
- Ignored inputs:
  - `uart_tx_done` in IDLE, SEND or GAP is ignored and causes no state change.
  - `tx_start` falling mid-word has no effect; the word always completes.
  - `tx_Data` changes after acceptance do not affect the word in flight.
- Reset (asynchronous, at any time, including mid-word):
  - state returns to IDLE; all counters and the shift register go to 0;
  - no `tx_done` is produced for the aborted word.
- Reset values of outputs: `uart_tx_data`=0, `uart_tx_start`=0, `tx_done`=0, `busy`=0.

## Timing
- Acceptance: `tx_start` high in IDLE at edge k. SEND and the first `uart_tx_start` pulse occur in cycle k+1.
- Per byte: one SEND cycle, then WAIT until the UART tick. The next SEND follows in the cycle after `uart_tx_done`.
- `tx_done` is high for the cycle immediately after the final `uart_tx_done`.
- Guard gap: IDLE is re-entered exactly GAP_CYCLES cycles after `tx_done` first rises. With `tx_start` held high, the next word is accepted on the first IDLE edge.
- The default GAP_CYCLES=3 covers the controller's delay between seeing `tx_done` and presenting a registered new word: address increment, synchronous memory read, then `tx_data` register.
- All outputs are decoded from registered state and counters. There are no combinational paths from inputs to outputs.

## Structure
- Shared package (shared with the debug controller and UART) holds:
  - state encoding localparams: IDLE, SEND, WAIT, GAP (2 bits);
  - the `NBYTES` derivation;
  - the debug link word width.
- No sub-module. Single FSM plus shift register and counters; it instantiates alongside the existing UART transmitter rather than containing it.

## Test plan
1. Single word: `tx_Data`=32'hA1B2C3D4, `tx_start` pulsed, UART model returning `uart_tx_done` 10 cycles after each start.
   - Expect 4 `uart_tx_start` pulses carrying D4, C3, B2, A1.
   - Expect exactly one `tx_done`, one cycle after the 4th tick.
   - Expect `busy` to fall 3 cycles later.
2. Back-to-back stream: `tx_start` held high; the bench changes `tx_Data` to 32'h00000011 2 cycles after `tx_done`.
   - Expect the second word to send bytes 11, 00, 00, 00.
   - Expect no byte of the first word to repeat.
3. Abort: assert `reset` low after the 2nd byte of 32'hDEADBEEF.
   - Expect all outputs 0 immediately and no `tx_done`.
   - After release, a new word 32'h01020304 sends 04, 03, 02, 01.
4. Stray ticks: inject `uart_tx_done` in IDLE, in GAP, and in the SEND cycle.
   - Expect no state change, no extra byte, and no `tx_done`.
5. Input stability: change `tx_Data` and drop `tx_start` during WAIT of byte 1.
   - Expect the original word to complete unchanged, then the block to remain in IDLE.
